// File: rtl/uc_pkg.sv
// Shared definitions for the microcontroller control unit: FSM states,
// opcode constants and the control word handed to the datapath.
package uc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    localparam logic [5:0] OP_J    = 6'b000000;
    localparam logic [5:0] OP_JZ   = 6'b000001;
    localparam logic [5:0] OP_JNZ  = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b000011;

    localparam logic [2:0] ALU_PASS = 3'b000;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we;
        logic       wez;
        logic [2:0] alu_op;
    } ctrl_t;

    // Control word for cycles in which nothing may be written and the PC advances.
    localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0,
                                    wez: 1'b0, alu_op: ALU_PASS};

endpackage

// File: rtl/uc_decode.sv
// Purely combinational opcode/zero-flag decode into a datapath control word,
// plus flags telling the FSM whether a jump is taken or a HALT was seen.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] Opcode,
    input  logic       zero,
    output ctrl_t      ctrl,
    output logic       taken,
    output logic       halt
);

    always_comb begin
        ctrl  = CTRL_IDLE;
        taken = 1'b0;
        halt  = 1'b0;
        if (Opcode[5]) begin
            ctrl.alu_op = Opcode[4:2];
            ctrl.we     = 1'b1;
            ctrl.wez    = 1'b1;
        end else if (Opcode[4]) begin
            ctrl.alu_op = Opcode[3:1];
            ctrl.s_inm  = 1'b1;
            ctrl.we     = 1'b1;
            ctrl.wez    = 1'b1;
        end else begin
            // Remaining 00xxxx codes: jumps and HALT, anything else is a NOP.
            case (Opcode)
                OP_J: begin
                    ctrl.s_inc = 1'b0;
                    taken      = 1'b1;
                end
                OP_JZ: begin
                    ctrl.s_inc = ~zero;
                    taken      = zero;
                end
                OP_JNZ: begin
                    ctrl.s_inc = zero;
                    taken      = ~zero;
                end
                OP_HALT: begin
                    ctrl.s_inc = 1'b0;
                    halt       = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uc_microc.sv
// Control unit for the single-cycle microcontroller: run/halt FSM, one-cycle
// flush after taken jumps, and a saturating retired-instruction counter.
module uc_microc
    import uc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    output logic             dp_reset,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state;
    state_t     state_next;
    logic       restart_pending;
    ctrl_t      dec_ctrl;
    ctrl_t      ctrl;
    logic       dec_taken;
    logic       dec_halt;

    uc_decode u_decode (
        .Opcode (Opcode),
        .zero   (zero),
        .ctrl   (dec_ctrl),
        .taken  (dec_taken),
        .halt   (dec_halt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start seen in HALTED passes through IDLE first, so remember it for one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            restart_pending <= 1'b0;
        end else if (state == ST_HALTED && start) begin
            restart_pending <= 1'b1;
        end else if (state == ST_IDLE) begin
            restart_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || state == ST_IDLE) begin
            instr_count <= '0;
        end else if (state == ST_RUN && instr_count != {CNT_W{1'b1}}) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        ctrl       = CTRL_IDLE;
        dp_reset   = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_IDLE: begin
                dp_reset = 1'b1;
                if (start || restart_pending) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                ctrl = dec_ctrl;
                if (dec_halt) begin
                    state_next = ST_HALTED;
                end else if (dec_taken) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy       = 1'b1;
                state_next = ST_RUN;
            end
            ST_HALTED: begin
                halted     = 1'b1;
                ctrl.s_inc = 1'b0;
                if (start) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign s_inc = ctrl.s_inc;
    assign s_inm = ctrl.s_inm;
    assign we    = ctrl.we;
    assign wez   = ctrl.wez;
    assign ALUOp = ctrl.alu_op;

endmodule

// File: tb/tb_uc_microc.sv
// Self-checking bench for uc_microc: directed scenarios followed by random
// opcodes, compared against a behavioural model of the control unit.
module tb_uc_microc;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  Opcode;
    logic        zero;

    logic        dp_reset, s_inc, s_inm, we, wez, busy, halted;
    logic [2:0]  ALUOp;
    logic [15:0] instr_count;

    logic        dp_reset4, s_inc4, s_inm4, we4, wez4, busy4, halted4;
    logic [2:0]  ALUOp4;
    logic [3:0]  instr_count4;

    int assertions = 0;
    int failures   = 0;

    // Model modes: 0 idle, 1 run, 2 flush, 3 halted
    int m_mode;
    int m_cnt;
    int m_cnt4;
    bit m_pending;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    uc_microc #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .Opcode(Opcode), .zero(zero),
        .dp_reset(dp_reset), .s_inc(s_inc), .s_inm(s_inm), .we(we), .wez(wez),
        .ALUOp(ALUOp), .busy(busy), .halted(halted), .instr_count(instr_count)
    );

    uc_microc #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .Opcode(Opcode), .zero(zero),
        .dp_reset(dp_reset4), .s_inc(s_inc4), .s_inm(s_inm4), .we(we4), .wez(wez4),
        .ALUOp(ALUOp4), .busy(busy4), .halted(halted4), .instr_count(instr_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int op;
        bit e_dp, e_busy, e_halt, e_inc, e_inm, e_we, e_wez;
        int e_alu;
        op     = int'(Opcode);
        e_dp   = (m_mode == 0);
        e_busy = (m_mode == 1 || m_mode == 2);
        e_halt = (m_mode == 3);
        e_inc  = (m_mode != 3);
        e_inm  = 0; e_we = 0; e_wez = 0; e_alu = 0;
        if (m_mode == 1) begin
            if (op >= 32) begin
                e_alu = (op / 4) % 8; e_we = 1; e_wez = 1;
            end else if (op >= 16) begin
                e_alu = (op / 2) % 8; e_inm = 1; e_we = 1; e_wez = 1;
            end else if (op == 0 || op == 3) begin
                e_inc = 0;
            end else if (op == 1) begin
                e_inc = !zero;
            end else if (op == 2) begin
                e_inc = zero;
            end
        end
        chk("dp_reset", 32'(dp_reset), 32'(e_dp));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("halted", 32'(halted), 32'(e_halt));
        chk("s_inc", 32'(s_inc), 32'(e_inc));
        chk("s_inm", 32'(s_inm), 32'(e_inm));
        chk("we", 32'(we), 32'(e_we));
        chk("wez", 32'(wez), 32'(e_wez));
        chk("ALUOp", 32'(ALUOp), 32'(e_alu));
        chk("instr_count", 32'(instr_count), 32'(m_cnt));
        chk("instr_count4", 32'(instr_count4), 32'(m_cnt4));
        chk("busy4", 32'(busy4), 32'(e_busy));
    endtask

    // One clock of stimulus: drive, check current-cycle outputs, then advance the model.
    task automatic applyStimulus(input bit r, input bit st, input logic [5:0] op, input bit z);
        int o;
        @(negedge clk);
        reset = r; start = st; Opcode = op; zero = z;
        #1;
        if (m_valid) checkOutput();
        @(posedge clk);
        o = int'(op);
        if (!r) begin
            m_mode = 0; m_cnt = 0; m_cnt4 = 0; m_pending = 0; m_valid = 1;
        end else begin
            case (m_mode)
                0: begin
                    m_cnt = 0; m_cnt4 = 0;
                    if (st || m_pending) m_mode = 1;
                    m_pending = 0;
                end
                1: begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
                    if (o == 3) m_mode = 3;
                    else if (o == 0 || (o == 1 && z) || (o == 2 && !z)) m_mode = 2;
                end
                2: m_mode = 1;
                default: if (st) begin m_mode = 0; m_pending = 1; end
            endcase
        end
    endtask

    initial begin
        int r;
        reset = 1'b0; start = 1'b0; Opcode = 6'b0; zero = 1'b0;
        m_mode = 0; m_cnt = 0; m_cnt4 = 0; m_pending = 0;

        $display("[TB] reset and idle");
        applyStimulus(0, 0, 6'b000000, 0);
        applyStimulus(0, 0, 6'b000000, 0);
        repeat (3) applyStimulus(1, 0, 6'(($urandom_range(0, 63))), 1'($urandom));

        $display("[TB] ALU reg-reg run");
        applyStimulus(1, 1, 6'b101000, 0);
        repeat (3) applyStimulus(1, 0, 6'b101000, 0);

        $display("[TB] conditional jumps");
        applyStimulus(1, 0, 6'b000001, 1);
        applyStimulus(1, 1, 6'b101000, 0);
        applyStimulus(1, 0, 6'b000001, 0);
        applyStimulus(1, 0, 6'b000010, 0);
        applyStimulus(1, 0, 6'b000100, 1);
        applyStimulus(1, 0, 6'b000010, 1);

        $display("[TB] saturation");
        repeat (20) applyStimulus(1, 0, 6'b011011, 0);

        $display("[TB] halt and restart");
        applyStimulus(1, 0, 6'b000011, 0);
        repeat (3) applyStimulus(1, 0, 6'b000011, 0);
        applyStimulus(1, 1, 6'b000011, 0);
        applyStimulus(1, 0, 6'b101000, 0);
        repeat (2) applyStimulus(1, 0, 6'b110100, 1);

        $display("[TB] reset during flush");
        applyStimulus(1, 0, 6'b000000, 0);
        applyStimulus(0, 1, 6'b101000, 0);
        repeat (2) applyStimulus(1, 0, 6'b101000, 0);

        $display("[TB] random phase");
        repeat (400) begin
            r = int'($urandom_range(0, 99));
            applyStimulus(r >= 2, ($urandom_range(0, 9) == 0),
                          (r < 45) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63)),
                          1'($urandom));
        end
        applyStimulus(1, 0, 6'b100000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
